// File: rtl/memory_stage.sv
// Memory stage of a five-stage pipeline: passes non-memory instructions
// through in one cycle, runs loads/stores as a blocking request/ready
// handshake with a timeout, and registers the write-back outputs.
module memory_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR_M,
  input  logic [31:0] ALU_output_M,
  input  logic [31:0] B_M,
  input  logic        valid_M,
  output logic        stall_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] IR_W,
  output logic [31:0] ALU_output_W,
  output logic [31:0] LMD_W,
  output logic        valid_W,
  output logic        mem_err
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ir_a_q, ir_a_d;
  logic [31:0]   addr_a_q, addr_a_d;
  logic [31:0]   wdata_a_q, wdata_a_d;
  logic          we_a_q, we_a_d;
  logic [31:0]   ir_w_q, ir_w_d;
  logic [31:0]   alu_w_q, alu_w_d;
  logic [31:0]   lmd_w_q, lmd_w_d;
  logic          valid_w_q, valid_w_d;
  logic          err_q, err_d;

  logic is_load_m, is_store_m, is_mem_m, in_access;

  // Decode the incoming instruction class
  always_comb begin
    is_load_m  = (IR_M[31:29] == 3'b100);
    is_store_m = (IR_M[31:29] == 3'b101);
    is_mem_m   = valid_M && (is_load_m || is_store_m);
  end

  // Next-state and write-back register computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ir_a_d    = ir_a_q;
    addr_a_d  = addr_a_q;
    wdata_a_d = wdata_a_q;
    we_a_d    = we_a_q;
    ir_w_d    = ir_w_q;
    alu_w_d   = alu_w_q;
    lmd_w_d   = lmd_w_q;
    valid_w_d = valid_w_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (!valid_M) begin
          ir_w_d    = '0;
          valid_w_d = 1'b0;
        end else if (is_mem_m) begin
          ir_a_d    = IR_M;
          addr_a_d  = ALU_output_M;
          wdata_a_d = B_M;
          we_a_d    = is_store_m;
          cnt_d     = '0;
          state_d   = ACCESS;
          ir_w_d    = '0;
          valid_w_d = 1'b0;
        end else begin
          ir_w_d    = IR_M;
          alu_w_d   = ALU_output_M;
          valid_w_d = 1'b1;
        end
      end
      ACCESS: begin
        // ready wins over a timeout landing on the same edge
        if (mem_ready) begin
          ir_w_d    = ir_a_q;
          alu_w_d   = addr_a_q;
          valid_w_d = 1'b1;
          if (!we_a_q) lmd_w_d = mem_rdata;
          state_d   = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d     = 1'b1;
          ir_w_d    = ir_a_q;
          alu_w_d   = addr_a_q;
          lmd_w_d   = '0;
          valid_w_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pipeline registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ir_a_q    <= '0;
      addr_a_q  <= '0;
      wdata_a_q <= '0;
      we_a_q    <= 1'b0;
      ir_w_q    <= '0;
      alu_w_q   <= '0;
      lmd_w_q   <= '0;
      valid_w_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ir_a_q    <= ir_a_d;
      addr_a_q  <= addr_a_d;
      wdata_a_q <= wdata_a_d;
      we_a_q    <= we_a_d;
      ir_w_q    <= ir_w_d;
      alu_w_q   <= alu_w_d;
      lmd_w_q   <= lmd_w_d;
      valid_w_q <= valid_w_d;
      err_q     <= err_d;
    end
  end

  // Memory interface and stall; rst gates them so they drop with no clock edge
  always_comb begin
    in_access = (state_q == ACCESS) && !rst;
    mem_req   = in_access;
    mem_we    = in_access && we_a_q;
    mem_addr  = in_access ? addr_a_q  : '0;
    mem_wdata = in_access ? wdata_a_q : '0;
    if (rst)            stall_M = 1'b0;
    else if (in_access) stall_M = !mem_ready;
    else                stall_M = is_mem_m;
  end

  assign IR_W         = ir_w_q;
  assign ALU_output_W = alu_w_q;
  assign LMD_W        = lmd_w_q;
  assign valid_W      = valid_w_q;
  assign mem_err      = err_q;

endmodule
